rob_multi: RTL and testbench

Parametrised reorder buffer that merges tagged read responses from `NUM_SRC` independent in-order sources (e.g. tag-compare hit path, CXL miss path, writeback-forward path) into one AXI-style R stream in strict transaction-ID order. It sits between the cache pipelines and the host R channel. It replaces the two-source ROB with four additions: N sources, AXI ID passthrough, full-throughput output register, and protocol-error detection.

---
 rtl/rob_pkg.sv | 28 ++
 rtl/rob_fifo.sv | 60 ++++++
 rtl/rob_multi.sv | 131 +++++++++++++
 tb/tb_rob_multi.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared constants, entry layout and helpers for the multi-source reorder buffer.
// Entries are packed {tid, rid, data}, MSB first.
package rob_pkg;

  localparam int AXI_DATA_WIDTH = 64;
  localparam int AXI_ID_WIDTH   = 8;
  localparam int ROB_TID_WIDTH  = 8;
  localparam int FIFO_SIZE      = 8;

  typedef struct packed {
    logic [ROB_TID_WIDTH-1:0]  tid;
    logic [AXI_ID_WIDTH-1:0]   rid;
    logic [AXI_DATA_WIDTH-1:0] data;
  } rob_entry_t;

  function automatic int entry_width(input int tid_w, input int id_w, input int data_w);
    return tid_w + id_w + data_w;
  endfunction

  function automatic int rid_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int tid_lsb(input int id_w, input int data_w);
    return id_w + data_w;
  endfunction

endpackage

// File: rtl/rob_fifo.sv
// Synchronous show-ahead FIFO: read_data_o always presents the head entry.
// full_o is registered and reflects occupancy before any same-cycle pop.
module rob_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en_i,
  input  logic [WIDTH-1:0] write_data_i,
  input  logic             read_en_i,
  output logic [WIDTH-1:0] read_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = write_en_i && !full_q;
    do_pop   = read_en_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    full_d   = (count_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset; pointers alone define what is queued.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wr_ptr_q] <= write_data_i;
    end
  end

  assign read_data_o = mem_q[rd_ptr_q];
  assign full_o      = full_q;
  assign empty_o     = (count_q == '0);

endmodule

// File: rtl/rob_multi.sv
// Reorder buffer merging NUM_SRC in-order tagged response streams into one
// AXI-style R stream in strict TID order, with sticky protocol-error detection.
module rob_multi
  import rob_pkg::*;
#(
  parameter int DATA_WIDTH  = AXI_DATA_WIDTH,
  parameter int ID_WIDTH    = AXI_ID_WIDTH,
  parameter int TID_WIDTH   = ROB_TID_WIDTH,
  parameter int NUM_SRC     = 2,
  parameter int FIFO_DEPTH  = FIFO_SIZE,
  parameter int TID_INIT    = 1,
  parameter int ENTRY_WIDTH = entry_width(TID_WIDTH, ID_WIDTH, DATA_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [ID_WIDTH-1:0]            rid_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [NUM_SRC-1:0]             full_o,
  input  logic [NUM_SRC-1:0]             write_en_i,
  input  logic [NUM_SRC*ENTRY_WIDTH-1:0] wdata_i,
  output logic [TID_WIDTH-1:0]           expected_tid_o,
  output logic                           err_o
);

  localparam int RID_LSB = rid_lsb(DATA_WIDTH);
  localparam int TID_LSB = tid_lsb(ID_WIDTH, DATA_WIDTH);

  logic [ENTRY_WIDTH-1:0] head [NUM_SRC];
  logic [NUM_SRC-1:0]     empty;
  logic [NUM_SRC-1:0]     match;
  logic [NUM_SRC-1:0]     grant;
  logic [NUM_SRC-1:0]     pop;

  logic                   valid_q, valid_d;
  logic [ID_WIDTH-1:0]    rid_q, rid_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;
  logic                   err_q, err_d;

  logic                   found;
  logic                   load;
  logic                   multi_match;
  logic                   overflow;
  logic                   deadlock;
  logic [ID_WIDTH-1:0]    win_rid;
  logic [DATA_WIDTH-1:0]  win_data;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    rob_fifo #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .write_en_i   (write_en_i[s]),
      .write_data_i (wdata_i[s*ENTRY_WIDTH +: ENTRY_WIDTH]),
      .read_en_i    (pop[s]),
      .read_data_o  (head[s]),
      .full_o       (full_o[s]),
      .empty_o      (empty[s])
    );

    assign match[s] = !empty[s] && (head[s][TID_LSB +: TID_WIDTH] == tid_q);
  end

  // Lowest-index matching source wins; any other matching head stays queued.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    win_rid  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (match[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        win_rid  = head[i][RID_LSB +: ID_WIDTH];
        win_data = head[i][DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    multi_match = ((match & (match - NUM_SRC'(1))) != '0);
    overflow    = |(write_en_i & full_o);
    // In-order sources with every head present but none matching can never progress.
    deadlock    = (&(~empty)) && (match == '0);
    load        = (|match) && (!valid_q || ready_i);
    pop         = load ? grant : '0;
  end

  always_comb begin
    valid_d = valid_q;
    rid_d   = rid_q;
    data_d  = data_q;
    tid_d   = tid_q;
    if (load) begin
      valid_d = 1'b1;
      rid_d   = win_rid;
      data_d  = win_data;
      tid_d   = tid_q + TID_WIDTH'(1);
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
    err_d = err_q | overflow | multi_match | deadlock;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rid_q   <= '0;
      data_q  <= '0;
      tid_q   <= TID_WIDTH'(TID_INIT);
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rid_q   <= rid_d;
      data_q  <= data_d;
      tid_q   <= tid_d;
      err_q   <= err_d;
    end
  end

  assign valid_o        = valid_q;
  assign rid_o          = rid_q;
  assign rdata_o        = data_q;
  assign expected_tid_o = tid_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: ordering, backpressure, TID wrap, full,
// deadlock, duplicate TID and mid-stream reset.
module tb_rob_multi;

  localparam int DW = 16;
  localparam int IW = 4;
  localparam int TW = 4;
  localparam int NS = 3;
  localparam int FD = 4;
  localparam int EW = TW + IW + DW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ready_i = 1'b0;
  logic             valid_o;
  logic [IW-1:0]    rid_o;
  logic [DW-1:0]    rdata_o;
  logic [NS-1:0]    full_o;
  logic [NS-1:0]    write_en_i = '0;
  logic [NS*EW-1:0] wdata_i = '0;
  logic [TW-1:0]    expected_tid_o;
  logic             err_o;

  int n_tests = 0;
  int n_fail  = 0;

  rob_multi #(
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .TID_WIDTH  (TW),
    .NUM_SRC    (NS),
    .FIFO_DEPTH (FD),
    .TID_INIT   (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .rid_o          (rid_o),
    .rdata_o        (rdata_o),
    .full_o         (full_o),
    .write_en_i     (write_en_i),
    .wdata_i        (wdata_i),
    .expected_tid_o (expected_tid_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_src(input int k, input logic [TW-1:0] tid, input logic [IW-1:0] rid,
                          input logic [DW-1:0] data);
    wdata_i[k*EW +: EW] = {tid, rid, data};
    write_en_i[k]       = 1'b1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    write_en_i = '0;
  endtask

  task automatic do_reset;
    rst        = 1'b1;
    write_en_i = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [IW-1:0] rid, input logic [DW-1:0] data,
                      input logic [TW-1:0] exp_tid);
    check({tag, ".valid"}, 32'(valid_o), 32'd1);
    check({tag, ".rid"}, 32'(rid_o), 32'(rid));
    check({tag, ".data"}, 32'(rdata_o), 32'(data));
    check({tag, ".exp_tid"}, 32'(expected_tid_o), 32'(exp_tid));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] tid;

    // Reset state
    step();
    do_reset();
    check("rst.valid", 32'(valid_o), 32'd0);
    check("rst.rid", 32'(rid_o), 32'd0);
    check("rst.data", 32'(rdata_o), 32'd0);
    check("rst.err", 32'(err_o), 32'd0);
    check("rst.full", 32'(full_o), 32'd0);
    check("rst.exp_tid", 32'(expected_tid_o), 32'd1);

    // Two sources interleaved, output in TID order on consecutive cycles
    ready_i = 1'b1;
    load_src(0, 4'd1, 4'h2, 16'h0101);
    load_src(1, 4'd2, 4'h1, 16'h0202);
    step();
    load_src(0, 4'd3, 4'h0, 16'h0303);
    load_src(1, 4'd4, 4'h7, 16'h0404);
    step();
    beat("ord1", 4'h2, 16'h0101, 4'd2);
    step();
    beat("ord2", 4'h1, 16'h0202, 4'd3);
    step();
    beat("ord3", 4'h0, 16'h0303, 4'd4);
    step();
    beat("ord4", 4'h7, 16'h0404, 4'd5);
    step();
    check("ord.idle", 32'(valid_o), 32'd0);
    check("ord.err", 32'(err_o), 32'd0);

    // Backpressure: output held stable while ready_i is low
    do_reset();
    ready_i = 1'b0;
    load_src(0, 4'd1, 4'h9, 16'hBEEF);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      beat("bp.hold", 4'h9, 16'hBEEF, 4'd2);
      step();
    end
    ready_i = 1'b1;
    beat("bp.release", 4'h9, 16'hBEEF, 4'd2);
    step();
    check("bp.after", 32'(valid_o), 32'd0);
    check("bp.after_tid", 32'(expected_tid_o), 32'd2);

    // Wrap-around: TIDs 1..15, 0, 1 alternating between src0 and src1
    do_reset();
    ready_i = 1'b1;
    for (int n = 0; n < 17; n++) begin
      tid = TW'((n + 1) % 16);
      load_src(n % 2, tid, tid ^ 4'hA, 16'h1000 + 16'(n));
      step();
      if (n >= 1) begin
        tid = TW'(n % 16);
        beat("wrap", tid ^ 4'hA, 16'h1000 + 16'(n - 1), tid + 4'd1);
      end
    end
    step();
    beat("wrap.last", 4'h1 ^ 4'hA, 16'h1010, 4'd2);
    check("wrap.err", 32'(err_o), 32'd0);

    // Full: src0 filled with non-matching entries, one overflow push dropped
    do_reset();
    ready_i = 1'b1;
    for (int t = 2; t <= 5; t++) begin
      load_src(0, TW'(t), IW'(t), 16'h4000 + 16'(t));
      step();
      if (t == 4) check("full.before", 32'(full_o), 32'd0);
    end
    check("full.set", 32'(full_o), 32'b001);
    check("full.noerr", 32'(err_o), 32'd0);
    load_src(0, 4'd6, 4'd6, 16'h4006);
    step();
    check("full.ovf_err", 32'(err_o), 32'd1);
    check("full.still", 32'(full_o), 32'b001);
    load_src(1, 4'd1, 4'd1, 16'h4001);
    step();
    step();
    beat("full.drain1", 4'd1, 16'h4001, 4'd2);
    for (int t = 2; t <= 5; t++) begin
      step();
      beat("full.drain", IW'(t), 16'h4000 + 16'(t), TW'(t + 1));
    end
    step();
    check("full.dropped", 32'(valid_o), 32'd0);
    check("full.end_tid", 32'(expected_tid_o), 32'd6);
    check("full.cleared", 32'(full_o), 32'd0);

    // Deadlock: every head holds a future TID
    do_reset();
    ready_i = 1'b1;
    load_src(0, 4'd5, 4'd5, 16'h5005);
    load_src(1, 4'd6, 4'd6, 16'h5006);
    load_src(2, 4'd7, 4'd7, 16'h5007);
    step();
    check("dl.pre_err", 32'(err_o), 32'd0);
    step();
    check("dl.err", 32'(err_o), 32'd1);
    check("dl.valid", 32'(valid_o), 32'd0);
    step();
    check("dl.valid2", 32'(valid_o), 32'd0);
    check("dl.tid", 32'(expected_tid_o), 32'd1);

    // Duplicate TID: src0 and src2 both hold TID 1, src0 wins
    do_reset();
    check("dup.rst_err", 32'(err_o), 32'd0);
    load_src(0, 4'd1, 4'h1, 16'h0B00);
    load_src(2, 4'd1, 4'h2, 16'h0B02);
    step();
    step();
    beat("dup.win", 4'h1, 16'h0B00, 4'd2);
    check("dup.err", 32'(err_o), 32'd1);
    step();
    check("dup.nosecond", 32'(valid_o), 32'd0);

    // Reset mid-stream with output held and three entries queued
    do_reset();
    ready_i = 1'b0;
    load_src(0, 4'd1, 4'h3, 16'h6001);
    load_src(1, 4'd2, 4'h3, 16'h6002);
    load_src(2, 4'd3, 4'h3, 16'h6003);
    step();
    load_src(0, 4'd4, 4'h3, 16'h6004);
    step();
    beat("mid.held", 4'h3, 16'h6001, 4'd2);
    rst = 1'b1;
    load_src(0, 4'd1, 4'h5, 16'h6666);
    load_src(1, 4'd1, 4'h5, 16'h6666);
    step();
    rst = 1'b0;
    check("mid.valid", 32'(valid_o), 32'd0);
    check("mid.full", 32'(full_o), 32'd0);
    check("mid.tid", 32'(expected_tid_o), 32'd1);
    check("mid.rid", 32'(rid_o), 32'd0);
    ready_i = 1'b1;
    step();
    step();
    check("mid.flushed", 32'(valid_o), 32'd0);
    check("mid.err", 32'(err_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
